tetris_input_conditioner: RTL and testbench

//  Upstream stage of the grid controller. Synchronises and debounces the four raw player buttons.

---
 rtl/tetris_input_conditioner_if.sv | 9 +
 rtl/tetris_input_conditioner.sv | 170 +++++++++++++++++
 tb/tb_tetris_input_conditioner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_conditioner_if.sv
// Command handshake between the input conditioner and the grid controller.
interface tetris_input_conditioner_if;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;

   modport master (output cmd, output cmd_valid, input cmd_ready);
   modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/tetris_input_conditioner.sv
// Synchronises and debounces the player buttons, turns presses (and held-move
// auto-repeats) into one-hot commands and offers them one at a time.
module tetris_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_DELAY    = 15000000,
   parameter int unsigned REPEAT_RATE     = 5000000,
   parameter int unsigned CNT_W           = 24
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [3:0]                  btn_raw,
   output logic [3:0]                  btn_level,
   tetris_input_conditioner_if.master  cmd_bus
);

   localparam int unsigned NB = 4;
   localparam int unsigned NR = 3;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic {IDLE, OFFER} state_t;

   logic [NB-1:0]    sync1, sync2;
   logic [CNT_W-1:0] db_cnt [NB];
   logic [NB-1:0]    level_q;
   logic [NB-1:0]    press_evt;
   logic [CNT_W-1:0] rpt_cnt [NR];
   logic [NR-1:0]    rpt_first;
   logic [NR-1:0]    rpt_evt;
   logic [NB-1:0]    events;
   logic [NB-1:0]    pend, pend_n;
   logic [NB-1:0]    clr, hold, top;
   logic [NB-1:0]    cmd_q, cmd_n;
   logic             valid_q, valid_n;
   state_t           state, state_n;

   // Highest-priority set bit: rotate > left > right > down.
   function automatic logic [3:0] pick_top(input logic [3:0] m);
      if (m[3])      return 4'b1000;
      else if (m[2]) return 4'b0100;
      else if (m[1]) return 4'b0010;
      else if (m[0]) return 4'b0001;
      else           return 4'b0000;
   endfunction

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: level follows the synced input after DEBOUNCE_CYCLES of disagreement.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_level <= '0;
         for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (sync2[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_level[i] <= sync2[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Delayed level copy used for rising-edge (press) detection.
   always_ff @(posedge clock) begin
      if (reset) level_q <= '0;
      else       level_q <= btn_level;
   end

   // Press events and auto-repeat events for the three move buttons.
   always_comb begin
      press_evt = btn_level & ~level_q;
      rpt_evt   = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         rpt_evt[i] = btn_level[i] && !press_evt[i] &&
                      (rpt_cnt[i] == (rpt_first[i] ? RD_LAST : RR_LAST));
      end
      events = press_evt | {1'b0, rpt_evt};
   end

   // Repeat timers: restart on press, run while held, clear on release.
   always_ff @(posedge clock) begin
      if (reset) begin
         rpt_first <= '1;
         for (int unsigned i = 0; i < NR; i++) rpt_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NR; i++) begin
            if (press_evt[i] || !btn_level[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b1;
            end else if (rpt_evt[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b0;
            end else begin
               rpt_cnt[i] <= rpt_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Offer FSM next-state, next command and pending-mask update.
   // A command still waiting on the bus counts as pending, so repeat presses of it merge.
   always_comb begin
      state_n = state;
      cmd_n   = cmd_q;
      clr     = '0;
      hold    = '0;
      top     = pick_top(pend);
      case (state)
         IDLE: begin
            if (pend != '0) begin
               state_n = OFFER;
               cmd_n   = top;
               clr     = top;
            end
         end
         OFFER: begin
            if (cmd_bus.cmd_ready) begin
               if (pend != '0) begin
                  cmd_n = top;
                  clr   = top;
               end else begin
                  state_n = IDLE;
                  cmd_n   = '0;
               end
            end else begin
               hold = cmd_q;
            end
         end
         default: begin
            state_n = IDLE;
            cmd_n   = '0;
         end
      endcase
      pend_n  = (pend & ~clr) | (events & ~hold);
      valid_n = (state_n == OFFER);
   end

   // FSM, pending mask and registered command outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         pend    <= '0;
         cmd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         pend    <= pend_n;
         cmd_q   <= cmd_n;
         valid_q <= valid_n;
      end
   end

   assign cmd_bus.cmd       = cmd_q;
   assign cmd_bus.cmd_valid = valid_q;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Directed bench for tetris_input_conditioner with short debounce/repeat timing.
module tb_tetris_input_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   int         checks = 0;
   int         failures = 0;

   int         cyc = 0;
   int         xn = 0;
   logic [3:0] xlog [0:255];
   int         xcyc [0:255];

   tetris_input_conditioner_if bus ();

   tetris_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE(8),
      .CNT_W(24)
   ) dut (
      .clock(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .cmd_bus(bus)
   );

   always #5 clk = ~clk;

   // Transfer log: every edge with valid && ready.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.cmd_valid && bus.cmd_ready && xn < 256) begin
         xlog[xn] <= bus.cmd;
         xcyc[xn] <= cyc;
         xn       <= xn + 1;
      end
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      btn_raw = 4'b0000;
      bus.cmd_ready = 1'b1;
      step(3);
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.cmd_valid); end
      checks++; if (bus.cmd !== 4'b0000) begin failures++; $display("FAIL reset_cmd got=%b exp=0000", bus.cmd); end
      checks++; if (btn_level !== 4'b0000) begin failures++; $display("FAIL reset_level got=%b exp=0000", btn_level); end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_rotate_latency;
      int base;
      base = xn;
      btn_raw = 4'b1000;
      step(7);
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL lat_edge7_valid got=%b exp=0", bus.cmd_valid); end
      step(1);
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL lat_edge8_valid got=%b exp=1", bus.cmd_valid); end
      checks++; if (bus.cmd !== 4'b1000) begin failures++; $display("FAIL lat_edge8_cmd got=%b exp=1000", bus.cmd); end
      step(1);
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL lat_edge9_valid got=%b exp=0", bus.cmd_valid); end
      checks++; if (btn_level !== 4'b1000) begin failures++; $display("FAIL rot_level got=%b exp=1000", btn_level); end
      step(51);
      btn_raw = 4'b0000;
      step(15);
      checks++; if (xn - base !== 1) begin failures++; $display("FAIL rot_no_repeat got=%0d exp=1", xn - base); end
   endtask

   task automatic test_glitch;
      int  base;
      logic seen;
      base = xn;
      seen = 1'b0;
      btn_raw = 4'b0001;
      step(3);
      btn_raw = 4'b0000;
      for (int k = 0; k < 20; k++) begin step(1); if (btn_level[0]) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch3_level got=%b exp=0", seen); end
      checks++; if (xn - base !== 0) begin failures++; $display("FAIL glitch3_cmds got=%0d exp=0", xn - base); end
      base = xn;
      btn_raw = 4'b0001;
      step(4);
      btn_raw = 4'b0000;
      for (int k = 0; k < 30; k++) begin step(1); if (btn_level[0]) seen = 1'b1; end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL pulse4_level got=%b exp=1", seen); end
      checks++; if (xn - base !== 1) begin failures++; $display("FAIL pulse4_cmds got=%0d exp=1", xn - base); end
      checks++; if (xlog[base] !== 4'b0001) begin failures++; $display("FAIL pulse4_cmd got=%b exp=0001", xlog[base]); end
   endtask

   task automatic test_repeat;
      int base;
      int exp_off [6];
      exp_off = '{0, 20, 28, 36, 44, 52};
      base = xn;
      btn_raw = 4'b0100;
      step(60);
      btn_raw = 4'b0000;
      step(40);
      checks++; if (xn - base !== 6) begin failures++; $display("FAIL repeat_count got=%0d exp=6", xn - base); end
      for (int k = 0; k < 6; k++) begin
         if (base + k < xn) begin
            checks++;
            if (xlog[base+k] !== 4'b0100 || xcyc[base+k] - xcyc[base] !== exp_off[k]) begin
               failures++;
               $display("FAIL repeat_%0d got cmd=%b off=%0d exp cmd=0100 off=%0d",
                        k, xlog[base+k], xcyc[base+k] - xcyc[base], exp_off[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int base;
      base = xn;
      bus.cmd_ready = 1'b0;
      btn_raw = 4'b0110;
      step(8);
      btn_raw = 4'b1110;
      step(10);
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold_valid got=%b exp=1", bus.cmd_valid); end
      checks++; if (bus.cmd !== 4'b0100) begin failures++; $display("FAIL b2b_hold_cmd got=%b exp=0100", bus.cmd); end
      btn_raw = 4'b0000;
      bus.cmd_ready = 1'b1;
      step(1);
      checks++; if (bus.cmd !== 4'b1000 || bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1000/1", bus.cmd, bus.cmd_valid); end
      step(1);
      checks++; if (bus.cmd !== 4'b0010 || bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_third got=%b/%b exp=0010/1", bus.cmd, bus.cmd_valid); end
      step(1);
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 4'b0000) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=0000/0", bus.cmd, bus.cmd_valid); end
      step(20);
      checks++; if (xn - base !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", xn - base); end
      checks++; if (xlog[base] !== 4'b0100) begin failures++; $display("FAIL b2b_first got=%b exp=0100", xlog[base]); end
   endtask

   task automatic test_merge;
      int base;
      base = xn;
      bus.cmd_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         btn_raw = 4'b0001;
         step(10);
         btn_raw = 4'b0000;
         step(10);
      end
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd !== 4'b0001) begin failures++; $display("FAIL merge_wait got=%b/%b exp=0001/1", bus.cmd, bus.cmd_valid); end
      bus.cmd_ready = 1'b1;
      step(20);
      checks++; if (xn - base !== 1) begin failures++; $display("FAIL merge_count got=%0d exp=1", xn - base); end
   endtask

   task automatic test_reset_mid;
      int   base;
      logic seen;
      seen = 1'b0;
      bus.cmd_ready = 1'b0;
      btn_raw = 4'b0001;
      step(8);
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", bus.cmd_valid); end
      btn_raw = 4'b0000;
      reset = 1'b1;
      step(1);
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 4'b0000 || btn_level !== 4'b0000)
         begin failures++; $display("FAIL rmid_post got=%b/%b/%b exp=0000/0/0000", bus.cmd, bus.cmd_valid, btn_level); end
      reset = 1'b0;
      bus.cmd_ready = 1'b1;
      base = xn;
      for (int k = 0; k < 40; k++) begin step(1); if (bus.cmd_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0 || xn - base !== 0) begin failures++; $display("FAIL rmid_no_replay got valid=%b cmds=%0d exp 0/0", seen, xn - base); end
   endtask

   initial begin
      reset = 1'b1;
      btn_raw = 4'b0000;
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_rotate_latency();
      test_glitch();
      test_repeat();
      test_back_to_back();
      test_merge();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
